// File: rtl/lc3b_types.sv
// Shared LC-3b types for the fetch stage: FSM states and the fetch queue entry layout.
package lc3b_types;

  localparam int LC3B_WIDTH = 16;

  typedef enum logic {
    FETCH_RUN,
    FETCH_DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [LC3B_WIDTH-1:0] pc;
    logic [LC3B_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous DEPTH-entry FIFO of {pc, instr}; head visible combinationally, one-cycle push-to-head.
// Flush and reset empty it; push must never be asserted when full.
module fetch_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_pc,
  input  logic [WIDTH-1:0]         push_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_pc,
  output logic [WIDTH-1:0]         head_instr
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// LC-3b fetch stage: fetch PC, trap/branch redirect, hold-until-response imem port, fetch queue.
// Response at edge N is visible at the queue head in cycle N+1; requests stop while the queue is full.
module fetch_unit
  import lc3b_types::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter int               INC      = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             redirect_trap,
  input  logic [WIDTH-1:0] trap_pc,
  input  logic             redirect_br,
  input  logic [WIDTH-1:0] target_pc,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_resp,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_pcplus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t     state, next_state;
  logic [WIDTH-1:0] fpc;
  logic [WIDTH-1:0] disc_addr;
  logic [WIDTH-1:0] new_pc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head_pc;
  logic [WIDTH-1:0] head_instr;
  logic             redirect;
  logic             full;
  logic             push;
  logic             pop;
  logic             go_discard;

  assign redirect = redirect_trap | redirect_br;
  assign new_pc   = redirect_trap ? trap_pc : target_pc;
  assign full     = (count == CW'(DEPTH));

  always_comb begin
    next_state = state;
    imem_read  = 1'b0;
    imem_addr  = fpc;
    go_discard = 1'b0;
    case (state)
      FETCH_RUN: begin
        imem_read = !full;
        // An issued read cannot be withdrawn, so a redirect parks its address until the response.
        if (redirect && !full && !imem_resp) begin
          next_state = FETCH_DISCARD;
          go_discard = 1'b1;
        end
      end
      FETCH_DISCARD: begin
        imem_read = 1'b1;
        imem_addr = disc_addr;
        if (imem_resp) next_state = FETCH_RUN;
      end
    endcase
    if (!reset_n) imem_read = 1'b0;
  end

  assign push = (state == FETCH_RUN) && !full && imem_resp && !redirect;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FETCH_RUN;
      fpc       <= RESET_PC;
      disc_addr <= '0;
    end else begin
      state <= next_state;
      if (redirect)      fpc <= new_pc;
      else if (push)     fpc <= fpc + WIDTH'(INC);
      if (go_discard)    disc_addr <= fpc;
    end
  end

  fetch_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_pc    (fpc),
    .push_instr (imem_rdata),
    .count      (count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  assign out_valid  = reset_n && (count != '0) && !redirect;
  assign pop        = out_valid && out_ready;
  assign out_pc     = reset_n ? head_pc : '0;
  assign out_instr  = reset_n ? head_instr : '0;
  assign out_pcplus = reset_n ? head_pc + WIDTH'(INC) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  localparam int          W        = 16;
  localparam int          D        = 4;
  localparam int          INC      = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_trap, redirect_br;
  logic [15:0] trap_pc, target_pc;
  logic        imem_read;
  logic [15:0] imem_addr;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr, out_pc, out_pcplus;

  fetch_unit #(.WIDTH(W), .DEPTH(D), .INC(INC), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .redirect_trap (redirect_trap),
    .trap_pc       (trap_pc),
    .redirect_br   (redirect_br),
    .target_pc     (target_pc),
    .imem_read     (imem_read),
    .imem_addr     (imem_addr),
    .imem_resp     (imem_resp),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pcplus    (out_pcplus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int lat   = 1;
  int mem_wait = 0;

  // Reference model: fetch PC, list of queued PCs, and a pending-discard flag.
  logic [15:0] m_fpc;
  logic [15:0] m_disc_addr;
  bit          m_disc;
  logic [15:0] q_pc[$];

  function automatic logic [15:0] mdata(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'd3;
    return t ^ 16'h5A5A;
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: memory responds, outputs are checked, model advances with the edge.
  task automatic tick();
    bit          e_read, e_valid, redir, pop;
    logic [15:0] e_addr, npc, pcv;
    #1;
    imem_resp  = imem_read && (mem_wait + 1 >= lat);
    imem_rdata = imem_resp ? mdata(imem_addr) : 16'hDEAD;
    #1;
    redir   = redirect_trap || redirect_br;
    npc     = redirect_trap ? trap_pc : target_pc;
    e_read  = reset_n && (m_disc || q_pc.size() < D);
    e_addr  = m_disc ? m_disc_addr : m_fpc;
    e_valid = reset_n && q_pc.size() != 0 && !redir;
    chk1("imem_read", imem_read, e_read);
    if (e_read) chk16("imem_addr", imem_addr, e_addr);
    chk1("out_valid", out_valid, e_valid);
    if (!reset_n) begin
      chk16("rst_out_pc", out_pc, 16'h0000);
      chk16("rst_out_instr", out_instr, 16'h0000);
      chk16("rst_out_pcplus", out_pcplus, 16'h0000);
    end else if (e_valid) begin
      pcv = q_pc[0];
      chk16("out_pc", out_pc, pcv);
      chk16("out_instr", out_instr, mdata(pcv));
      chk16("out_pcplus", out_pcplus, pcv + 16'(INC));
    end
    pop = e_valid && out_ready;
    if (!reset_n) begin
      m_fpc = RESET_PC;
      m_disc = 0;
      q_pc.delete();
    end else if (redir) begin
      q_pc.delete();
      if (m_disc) begin
        if (imem_resp) m_disc = 0;
      end else if (e_read && !imem_resp) begin
        m_disc = 1;
        m_disc_addr = m_fpc;
      end
      m_fpc = npc;
    end else if (m_disc) begin
      if (imem_resp) m_disc = 0;
    end else begin
      if (pop) void'(q_pc.pop_front());
      if (imem_resp) begin
        q_pc.push_back(m_fpc);
        m_fpc = m_fpc + 16'(INC);
      end
    end
    if (!reset_n || !imem_read || imem_resp) mem_wait = 0;
    else mem_wait++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n = 0; redirect_trap = 0; redirect_br = 0;
    trap_pc = 16'h0; target_pc = 16'h0; out_ready = 1;
    imem_resp = 0; imem_rdata = 16'h0;
    m_fpc = RESET_PC; m_disc = 0; m_disc_addr = 16'h0;
    @(negedge clk);

    // Reset, then sequential streaming with a 1-cycle memory.
    ticks(2);
    reset_n = 1;
    #1; chk16("first_addr", imem_addr, RESET_PC);
    ticks(1);
    #1; chk16("second_addr", imem_addr, 16'h0002);
    ticks(7);

    // Decode stalled: queue fills, reads stop, then resume.
    out_ready = 0;
    ticks(7);
    #1; chk1("full_read_low", imem_read, 1'b0);
    out_ready = 1;
    ticks(4);

    // Slow memory with a branch mid-wait.
    lat = 3;
    ticks(4);
    redirect_br = 1; target_pc = 16'h3000;
    ticks(1);
    redirect_br = 0;
    ticks(8);

    // Simultaneous trap and branch: trap wins.
    lat = 1;
    redirect_trap = 1; trap_pc = 16'h0400;
    redirect_br = 1; target_pc = 16'h2000;
    ticks(1);
    redirect_trap = 0; redirect_br = 0;
    #1; chk16("trap_priority", imem_addr, 16'h0400);
    ticks(4);

    // Address wrap.
    redirect_br = 1; target_pc = 16'hFFFE;
    ticks(1);
    redirect_br = 0;
    ticks(1);
    #1; chk16("wrap_pcplus", out_pcplus, 16'h0000);
    ticks(3);

    // Reset during an outstanding read.
    lat = 3;
    ticks(2);
    reset_n = 0;
    ticks(1);
    reset_n = 1;
    #1; chk16("post_reset_addr", imem_addr, RESET_PC);
    ticks(6);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      lat           = int'($urandom_range(1, 3));
      out_ready     = ($urandom_range(0, 99) < 70);
      redirect_br   = ($urandom_range(0, 99) < 8);
      redirect_trap = ($urandom_range(0, 99) < 3);
      target_pc     = 16'($urandom()) & 16'hFFFE;
      trap_pc       = 16'($urandom()) & 16'hFFFE;
      reset_n       = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
